// File: rtl/bank_if.sv
// bank_if: fill/read bus between a bank and its producer/consumer.
interface bank_if;
   logic        beg_en;
   logic [63:0] ref_in;
   logic        Bank_sel;
   logic [6:0]  address;
   logic        rd_en;
   logic [63:0] ref_ou;
   modport master (output beg_en, ref_in, Bank_sel, address, rd_en, input ref_ou);
   modport slave (input beg_en, ref_in, Bank_sel, address, rd_en, output ref_ou);
endinterface

// File: rtl/bank.sv
// bank: 128x64 ping-pong fill buffer, sequential fill pointer, registered read port.
module bank (
   input logic   clk,
   input logic   rst_n,
   bank_if.slave bus
);
   logic [63:0] mem_q [128];
   logic [6:0]  wr_ptr_q, wr_ptr_d;
   logic [63:0] ref_ou_q, ref_ou_d;
   logic        wr_en;
   // rst_n is active-high; writes are held off while it is asserted
   always_comb begin
      wr_en    = bus.beg_en & ~bus.Bank_sel & ~rst_n;
      wr_ptr_d = wr_en ? wr_ptr_q + 7'd1 : wr_ptr_q;
      ref_ou_d = bus.rd_en ? ref_ou_q : mem_q[bus.address];
   end
   always_ff @(posedge clk)
      if (wr_en) mem_q[wr_ptr_q] <= bus.ref_in;
   always_ff @(posedge clk or posedge rst_n)
      if (rst_n) begin
         wr_ptr_q <= '0;
         ref_ou_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         ref_ou_q <= ref_ou_d;
      end
   assign bus.ref_ou = ref_ou_q;
endmodule

// File: tb/tb_bank.sv
// tb_bank: directed scenarios plus random traffic against a row-array reference model.
module tb_bank;
   logic clk = 1'b0;
   logic rst_n;
   bank_if bus ();
   bank dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   logic [63:0] mm [128];
   bit          written [128];
   int          ptr;
   logic [63:0] exp_out;
   bit          exp_known;
   int          tests = 0;
   int          fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic beg, input logic [63:0] d, input logic sel,
                        input logic [6:0] a, input logic rd);
      bus.beg_en = beg; bus.ref_in = d; bus.Bank_sel = sel; bus.address = a; bus.rd_en = rd;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (!bus.rd_en) begin
         exp_known = written[bus.address];
         exp_out = mm[bus.address];
      end
      if (bus.beg_en && !bus.Bank_sel) begin
         mm[ptr] = bus.ref_in;
         written[ptr] = 1'b1;
         ptr = (ptr + 1) % 128;
      end
      #1;
      if (exp_known) check(tag, bus.ref_ou, exp_out);
      @(negedge clk);
   endtask

   task automatic reset_pulse(input string tag);
      #2 rst_n = 1'b1;
      ptr = 0; exp_out = '0; exp_known = 1'b1;
      #1 check(tag, bus.ref_ou, 64'd0);
      #1 rst_n = 1'b0;
   endtask

   initial begin
      logic [63:0] v0f, v55, v33;
      v0f = {8{8'h0F}}; v55 = {8{8'h55}}; v33 = {8{8'h33}};
      rst_n = 1'b1;
      ptr = 0; exp_out = '0; exp_known = 1'b1;
      drive(1'b0, '0, 1'b0, 7'd0, 1'b1);
      #3 check("reset_out", bus.ref_ou, 64'd0);
      @(negedge clk);
      check("reset_hold", bus.ref_ou, 64'd0);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin drive(1'b1, v0f, 1'b0, 7'd0, 1'b1); tick("s1_w"); end
      for (int i = 0; i < 3; i++) begin drive(1'b1, v55, 1'b0, 7'd0, 1'b1); tick("s1_w"); end
      drive(1'b1, v33, 1'b0, 7'd0, 1'b1); tick("s1_w");
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, '0, 1'b0, 7'(i), 1'b0); tick("s1_rd");
         check("s1_row", bus.ref_ou, i < 3 ? v0f : v55);
      end
      drive(1'b0, '0, 1'b0, 7'd6, 1'b0); tick("s1_rd6");
      check("s1_row6", bus.ref_ou, v33);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b0, 7'(i), 1'b1); tick("s2_hold");
         check("s2_hold_c", bus.ref_ou, v33);
      end
      reset_pulse("s4_rst");
      for (int i = 0; i < 130; i++) begin drive(1'b1, 64'(i), 1'b0, 7'd0, 1'b1); tick("s4_w"); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b0, 7'(i), 1'b0); tick("s4_rd");
         check("s4_row", bus.ref_ou, i == 0 ? 64'd128 : i == 1 ? 64'd129 : 64'd2);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, {$urandom, $urandom}, 1'b1, 7'd0, 1'b1); tick("s3_blk");
      end
      drive(1'b1, 64'hA5A5_0000_DEAD_BEEF, 1'b0, 7'd0, 1'b1); tick("s3_w");
      for (int i = 2; i < 8; i++) begin
         drive(1'b0, '0, 1'b0, 7'(i), 1'b0); tick("s3_rd");
         check("s3_row", bus.ref_ou, i == 2 ? 64'hA5A5_0000_DEAD_BEEF : 64'(i));
      end
      for (int i = 3; i < 7; i++) begin drive(1'b1, 64'(1000 + i), 1'b0, 7'd0, 1'b1); tick("s5_w"); end
      drive(1'b1, 64'h7777_7777, 1'b0, 7'd7, 1'b0); tick("s5_rbw");
      check("s5_old", bus.ref_ou, 64'd7);
      drive(1'b0, '0, 1'b0, 7'd7, 1'b0); tick("s5_rd");
      check("s5_new", bus.ref_ou, 64'h7777_7777);
      drive(1'b1, 64'h1111, 1'b0, 7'd0, 1'b1); tick("s6_w");
      drive(1'b1, 64'h2222, 1'b0, 7'd0, 1'b1); tick("s6_w");
      drive(1'b1, 64'hBEEF_CAFE, 1'b0, 7'd0, 1'b1);
      reset_pulse("s6_async");
      tick("s6_w0");
      drive(1'b0, '0, 1'b0, 7'd0, 1'b0); tick("s6_rd0");
      check("s6_row0", bus.ref_ou, 64'hBEEF_CAFE);
      drive(1'b0, '0, 1'b0, 7'd50, 1'b0); tick("s6_rd50");
      check("s6_row50", bus.ref_ou, 64'd50);
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom % 2), {$urandom, $urandom}, 1'($urandom % 4 == 0),
               7'($urandom % 128), 1'($urandom % 3 == 0));
         if ($urandom % 60 == 0) reset_pulse("rnd_rst");
         tick("rnd");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
